// File: rtl/mmio_io_ctrl_if.sv
// Processor data-bus port for memory-mapped peripherals.
// The master drives address, strobes and write data; the slave returns read data.
interface mmio_io_ctrl_if #(
  parameter int unsigned DBITS = 32
) ();
  logic [DBITS-1:0] addr_in;
  logic             wr_en;
  logic [DBITS-1:0] wr_data;
  logic             rd_en;
  logic [DBITS-1:0] rd_data;
  logic             rd_valid;

  modport master (
    output addr_in, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  addr_in, wr_en, wr_data, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O: debounced SW/KEY with sticky key-press flags,
// registered LEDR/LEDG and a seven-segment HEX display.
module mmio_io_ctrl #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(32'hF000_0000),
  parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(32'hF000_0004),
  parameter logic [DBITS-1:0] ADDR_LEDG       = DBITS'(32'hF000_0008),
  parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(32'hF000_0010),
  parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(32'hF000_0014),
  parameter logic [DBITS-1:0] ADDR_KEYEDGE    = DBITS'(32'hF000_0018),
  parameter int unsigned      NKEYS           = 4,
  parameter int unsigned      NSW             = 10,
  parameter int unsigned      NLEDR           = 10,
  parameter int unsigned      NLEDG           = 8,
  parameter int unsigned      NHEX            = 6,
  parameter int unsigned      DEBOUNCE_CYCLES = 16
) (
  input  logic               CLOCK_50,
  input  logic               FPGA_RESET_N,
  mmio_io_ctrl_if.slave      bus,
  input  logic [NKEYS-1:0]   KEY,
  input  logic [NSW-1:0]     SW,
  output logic [NLEDR-1:0]   LEDR,
  output logic [NLEDG-1:0]   LEDG,
  output logic [7*NHEX-1:0]  HEX
);

  localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned   HBITS    = 4 * NHEX;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Key inputs are active-low, so their idle (released) value is all ones.
  logic [NKEYS-1:0] key_meta, key_sync, key_stable;
  logic [NKEYS-1:0] key_upd_c, key_fall_c, key_pressed_c;
  logic [CW-1:0]    key_cnt [NKEYS];

  logic [NSW-1:0]   sw_meta, sw_sync, sw_stable;
  logic [NSW-1:0]   sw_upd_c;
  logic [CW-1:0]    sw_cnt [NSW];

  logic [NKEYS-1:0] key_edge, edge_clr_c;
  logic [HBITS-1:0] hex_reg;
  logic             hex_blank;
  logic [7*NHEX-1:0] hex_next_c;

  logic             wr_hex_c, wr_ledr_c, wr_ledg_c, wr_edge_c;
  logic [DBITS-1:0] rd_mux_c;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^bus.wr_data;

  // Seven-segment decode, active-low, bit0 = segment a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A bit commits on its DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    key_upd_c = '0;
    sw_upd_c  = '0;
    for (int i = 0; i < NKEYS; i++)
      key_upd_c[i] = (key_sync[i] != key_stable[i]) && (key_cnt[i] == CNT_LAST);
    for (int i = 0; i < NSW; i++)
      sw_upd_c[i] = (sw_sync[i] != sw_stable[i]) && (sw_cnt[i] == CNT_LAST);
  end

  assign key_fall_c    = key_upd_c & key_stable;
  assign key_pressed_c = ~key_stable;

  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      key_meta   <= '1;
      key_sync   <= '1;
      key_stable <= '1;
      for (int i = 0; i < NKEYS; i++) key_cnt[i] <= '0;
    end else begin
      key_meta   <= KEY;
      key_sync   <= key_meta;
      key_stable <= key_stable ^ key_upd_c;
      for (int i = 0; i < NKEYS; i++) begin
        if ((key_sync[i] == key_stable[i]) || key_upd_c[i]) key_cnt[i] <= '0;
        else                                                 key_cnt[i] <= key_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      for (int i = 0; i < NSW; i++) sw_cnt[i] <= '0;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      sw_stable <= sw_stable ^ sw_upd_c;
      for (int i = 0; i < NSW; i++) begin
        if ((sw_sync[i] == sw_stable[i]) || sw_upd_c[i]) sw_cnt[i] <= '0;
        else                                              sw_cnt[i] <= sw_cnt[i] + 1'b1;
      end
    end
  end

  // Write address decode; KEY, SW and unmapped addresses fall through.
  always_comb begin
    wr_hex_c   = 1'b0;
    wr_ledr_c  = 1'b0;
    wr_ledg_c  = 1'b0;
    wr_edge_c  = 1'b0;
    edge_clr_c = '0;
    if (bus.wr_en) begin
      wr_hex_c  = (bus.addr_in == ADDR_HEX);
      wr_ledr_c = (bus.addr_in == ADDR_LEDR);
      wr_ledg_c = (bus.addr_in == ADDR_LEDG);
      wr_edge_c = (bus.addr_in == ADDR_KEYEDGE);
    end
    if (wr_edge_c) edge_clr_c = bus.wr_data[NKEYS-1:0];
  end

  // Sticky press flags; a press landing on a clear keeps the flag set.
  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) key_edge <= '0;
    else               key_edge <= (key_edge & ~edge_clr_c) | key_fall_c;
  end

  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      LEDR      <= '0;
      LEDG      <= '0;
      hex_reg   <= '0;
      hex_blank <= 1'b1;
    end else begin
      if (wr_ledr_c) LEDR <= bus.wr_data[NLEDR-1:0];
      if (wr_ledg_c) LEDG <= bus.wr_data[NLEDG-1:0];
      if (wr_hex_c) begin
        hex_reg   <= bus.wr_data[HBITS-1:0];
        hex_blank <= 1'b0;
      end
    end
  end

  // Read mux sees pre-write register values, so same-cycle RAW returns old data.
  always_comb begin
    rd_mux_c = '0;
    if      (bus.addr_in == ADDR_HEX)     rd_mux_c = DBITS'(hex_reg);
    else if (bus.addr_in == ADDR_LEDR)    rd_mux_c = DBITS'(LEDR);
    else if (bus.addr_in == ADDR_LEDG)    rd_mux_c = DBITS'(LEDG);
    else if (bus.addr_in == ADDR_KEY)     rd_mux_c = DBITS'(key_pressed_c);
    else if (bus.addr_in == ADDR_SW)      rd_mux_c = DBITS'(sw_stable);
    else if (bus.addr_in == ADDR_KEYEDGE) rd_mux_c = DBITS'(key_edge);
  end

  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux_c;
    end
  end

  always_comb begin
    hex_next_c = '1;
    for (int i = 0; i < NHEX; i++)
      hex_next_c[7*i +: 7] = hex_blank ? 7'h7F : seg7(hex_reg[4*i +: 4]);
  end

  always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) HEX <= '1;
    else               HEX <= hex_next_c;
  end

endmodule
